// File: rtl/i_cache_burst_if.sv
// Fetch-side and Wishbone B4 signals of the burst instruction cache.
// The master modport is the cache's view; slave is the core/memory side.
interface i_cache_burst_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic [31:0]       INS;
    logic              ins_valid;
    logic              ins_err;
    logic              stall;
    logic              flush;
    logic              ACK;
    logic              ERR;
    logic              RTY;
    logic              STB;
    logic              CYC;
    logic              WE;
    logic [ADDR_W-1:0] ADR;
    logic [31:0]       DAT_I;
    logic [31:0]       DAT_O;
    logic [2:0]        CTI_O;

    modport master (
        input  req_valid, req_addr, flush,
        input  ACK, ERR, RTY, DAT_I,
        output req_ready, INS, ins_valid, ins_err, stall,
        output STB, CYC, WE, ADR, DAT_O, CTI_O
    );

    modport slave (
        output req_valid, req_addr, flush,
        output ACK, ERR, RTY, DAT_I,
        input  req_ready, INS, ins_valid, ins_err, stall,
        input  STB, CYC, WE, ADR, DAT_O, CTI_O
    );
endinterface

// File: rtl/i_cache_burst.sv
// Direct-mapped instruction cache with Wishbone B4 incrementing-burst refill,
// bus error reporting, retry handling and global flush.
module i_cache_burst #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int ADDR_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    i_cache_burst_if.master bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:2]  addr_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS*LINE_WORDS];
    logic [OFF_W-1:0]   beat_q;
    logic               cyc_q;
    logic               stb_q;
    logic [2:0]         cti_q;
    logic [ADDR_W-1:0]  adr_q;
    logic               ins_valid_q;
    logic               ins_err_q;
    logic [31:0]        ins_q;
    logic               flushed_q;

    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        rd_word;
    logic               hit;
    logic               req_ready;
    logic               last_beat;
    logic               wr_en;

    assign idx     = addr_q[OFF_W+2 +: IDX_W];
    assign off     = addr_q[2 +: OFF_W];
    assign tag     = addr_q[ADDR_W-1 -: TAG_W];
    assign rd_word = data_q[{idx, off}];

    // A flush in the lookup cycle forces a miss.
    assign hit = valid_q[idx] && (tag_q[idx] == tag) && !bus.flush;

    assign req_ready = (state_q == S_IDLE) ||
                       ((state_q == S_LOOKUP) && hit);

    assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));

    assign wr_en = (state_q == S_REFILL) && stb_q &&
                   bus.ACK && !bus.ERR && !bus.RTY;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{idx, beat_q}] <= bus.DAT_I;
            if (last_beat) begin
                tag_q[idx] <= tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            valid_q     <= '0;
            beat_q      <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cti_q       <= 3'b000;
            adr_q       <= '0;
            ins_valid_q <= 1'b0;
            ins_err_q   <= 1'b0;
            ins_q       <= '0;
            flushed_q   <= 1'b0;
        end else begin
            ins_valid_q <= 1'b0;
            ins_err_q   <= 1'b0;
            if (bus.flush) begin
                valid_q <= '0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr[ADDR_W-1:2];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        ins_valid_q <= 1'b1;
                        ins_q       <= rd_word;
                        if (bus.req_valid) begin
                            addr_q <= bus.req_addr[ADDR_W-1:2];
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        // Old contents are overwritten beat by beat.
                        valid_q[idx] <= 1'b0;
                        cyc_q        <= 1'b1;
                        stb_q        <= 1'b1;
                        cti_q        <= 3'b010;
                        adr_q        <= {addr_q[ADDR_W-1:OFF_W+2],
                                         (OFF_W + 2)'(0)};
                        beat_q       <= '0;
                        flushed_q    <= 1'b0;
                        state_q      <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                    end else if (bus.ERR) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        cti_q     <= 3'b000;
                        ins_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (bus.RTY) begin
                        stb_q <= 1'b0;
                    end else if (bus.ACK) begin
                        if (last_beat) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            cti_q   <= 3'b000;
                            state_q <= S_RESP;
                            if (!flushed_q && !bus.flush) begin
                                valid_q[idx] <= 1'b1;
                            end
                        end else begin
                            adr_q  <= adr_q + ADDR_W'(4);
                            beat_q <= beat_q + OFF_W'(1);
                            if (beat_q == OFF_W'(LINE_WORDS - 2)) begin
                                cti_q <= 3'b111;
                            end else begin
                                cti_q <= 3'b010;
                            end
                        end
                    end
                end
                S_RESP: begin
                    ins_valid_q <= 1'b1;
                    ins_q       <= rd_word;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.INS       = ins_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.ins_err   = ins_err_q;
    assign bus.stall     = (state_q != S_IDLE);
    assign bus.STB       = stb_q;
    assign bus.CYC       = cyc_q;
    assign bus.WE        = 1'b0;
    assign bus.ADR       = adr_q;
    assign bus.DAT_O     = 32'h0;
    assign bus.CTI_O     = cti_q;
endmodule

// File: tb/tb_i_cache_burst.sv
// Directed and randomized bench for i_cache_burst with a Wishbone memory
// model and an abstract set/tag reference of cache contents.
module tb_i_cache_burst;
    localparam int LW   = 4;
    localparam int SETS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i_cache_burst_if #(.ADDR_W(32)) bus ();

    i_cache_burst #(
        .LINE_WORDS(LW),
        .SETS      (SETS),
        .ADDR_W    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int nbursts = 0;
    int nacks   = 0;
    int stb_low = 0;
    int err_at  = -1;
    int rty_at  = -1;
    int wait_lo = 0;
    int wait_hi = 0;
    int wcnt    = 0;
    int wlim    = 0;
    bit prev_cyc = 0;
    logic [31:0] rty_adr;
    logic [34:0] beatq[$];

    bit          mvalid[SETS];
    logic [31:0] mtag[SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mvalid[i] = 0;
    endtask

    // Wishbone slave memory with wait states and one-shot ERR/RTY injection
    initial begin
        bus.ACK   = 1'b0;
        bus.ERR   = 1'b0;
        bus.RTY   = 1'b0;
        bus.DAT_I = 32'h0;
        forever begin
            @(negedge clk);
            bus.ACK = 1'b0;
            bus.ERR = 1'b0;
            bus.RTY = 1'b0;
            if (rst === 1'b1 || !bus.CYC) begin
                nacks    = 0;
                wcnt     = 0;
                prev_cyc = 0;
                wlim     = $urandom_range(wait_hi, wait_lo);
            end else begin
                if (!prev_cyc) nbursts++;
                prev_cyc = 1;
                if (!bus.STB) begin
                    stb_low++;
                    wcnt = 0;
                end else if (wcnt < wlim) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    wlim = $urandom_range(wait_hi, wait_lo);
                    if (nacks == err_at) begin
                        bus.ERR = 1'b1;
                    end else if (nacks == rty_at) begin
                        bus.RTY = 1'b1;
                        rty_at  = -1;
                        rty_adr = bus.ADR;
                    end else begin
                        bus.ACK   = 1'b1;
                        bus.DAT_I = mem_word(bus.ADR);
                        beatq.push_back({bus.CTI_O, bus.ADR});
                        nacks++;
                    end
                end
            end
        end
    end

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_clear();
    endtask

    task automatic do_fetch(input logic [31:0] a, input int eb,
                            input int rb, input bit fl);
        int set;
        int b0;
        int n;
        int cyc;
        bit miss;
        bit xerr;
        bit xrty;
        logic [31:0] base;
        set  = int'((a >> 4) % SETS);
        miss = !mvalid[set] || (mtag[set] != (a >> 10));
        xerr = miss && eb >= 0 && eb < LW;
        xrty = miss && rb >= 0 && rb < LW && (!xerr || rb < eb);
        base = a & 32'hFFFF_FFF0;
        b0 = nbursts;
        beatq.delete();
        stb_low = 0;
        err_at = miss ? eb : -1;
        rty_at = miss ? rb : -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready", 32'(cyc < 50), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!(bus.ins_valid || bus.ins_err) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && miss) begin
                chk("busy_ready", 32'(bus.req_ready), 0);
                chk("busy_stall", 32'(bus.stall), 1);
            end
            if (fl && cyc == 2) bus.flush = 1'b1;
            if (fl && cyc == 3) bus.flush = 1'b0;
        end
        bus.flush = 1'b0;
        chk("timeout", 32'(cyc < 400), 1);
        chk("ins_err", 32'(bus.ins_err), 32'(xerr));
        chk("ins_valid", 32'(bus.ins_valid), 32'(!xerr));
        if (!xerr) chk("INS", bus.INS, mem_word(a & 32'hFFFF_FFFC));
        if (!miss) chk("hit_latency", cyc, 1);
        chk("cyc_done", 32'(bus.CYC), 0);
        chk("bursts", nbursts - b0, 32'(miss));
        n = xerr ? eb : (miss ? LW : 0);
        chk("beats", beatq.size(), n);
        for (int i = 0; i < beatq.size() && i < n; i++) begin
            chk("beat_adr", beatq[i][31:0], base + 32'(4 * i));
            chk("beat_cti", 32'(beatq[i][34:32]),
                (i == LW - 1) ? 32'd7 : 32'd2);
        end
        chk("stb_low", stb_low, 32'(xrty));
        if (xrty) chk("rty_adr", rty_adr, base + 32'(4 * rb));
        if (xerr) begin
            @(negedge clk);
            chk("err_pulse", 32'(bus.ins_err), 0);
        end
        err_at = -1;
        rty_at = -1;
        if (miss) begin
            if (xerr) begin
                mvalid[set] = 0;
            end else if (fl) begin
                model_clear();
            end else begin
                mvalid[set] = 1;
                mtag[set]   = a >> 10;
            end
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] tags[4];
        logic [31:0] a;
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h20_0000;
        tags[3] = 32'h3F_FFFF;
        model_clear();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(bus.CYC), 0);
        chk("rst_stb", 32'(bus.STB), 0);
        chk("rst_cti", 32'(bus.CTI_O), 0);
        chk("rst_adr", bus.ADR, 0);
        chk("rst_ins_valid", 32'(bus.ins_valid), 0);
        chk("rst_ins_err", 32'(bus.ins_err), 0);
        chk("rst_INS", bus.INS, 0);
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_stall", 32'(bus.stall), 0);
        rst = 1'b0;

        // reset in the middle of a refill burst
        wait_lo = 2;
        wait_hi = 2;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!(bus.CYC && bus.ADR == 32'h108) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_beat2", 32'(cyc < 100), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cyc", 32'(bus.CYC), 0);
        chk("midrst_stb", 32'(bus.STB), 0);
        chk("midrst_cti", 32'(bus.CTI_O), 0);
        chk("midrst_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        wait_lo = 0;
        wait_hi = 0;

        // cold miss then hit in the same line
        do_fetch(32'h100, -1, -1, 0);
        do_fetch(32'h108, -1, -1, 0);

        // conflicting index evicts
        do_fetch(32'h500, -1, -1, 0);
        do_fetch(32'h100, -1, -1, 0);

        // back-to-back hits at one per cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h100;
        @(negedge clk);
        chk("b2b_ready", 32'(bus.req_ready), 1);
        bus.req_addr = 32'h108;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_v0", 32'(bus.ins_valid), 1);
        chk("b2b_i0", bus.INS, mem_word(32'h100));
        @(negedge clk);
        chk("b2b_v1", 32'(bus.ins_valid), 1);
        chk("b2b_i1", bus.INS, mem_word(32'h108));

        // bus error on beat 2, then refetch
        do_fetch(32'h200, 2, -1, 0);
        do_fetch(32'h200, -1, -1, 0);

        // retry on beat 1 with 3-cycle wait states
        do_flush();
        wait_lo = 3;
        wait_hi = 3;
        do_fetch(32'h100, -1, 1, 0);
        wait_lo = 0;
        wait_hi = 0;
        do_fetch(32'h104, -1, -1, 0);
        do_fetch(32'h108, -1, -1, 0);
        do_fetch(32'h10C, -1, -1, 0);

        // flush in idle after a hit, then flush during a refill
        do_fetch(32'h100, -1, -1, 0);
        do_flush();
        do_fetch(32'h100, -1, -1, 0);
        do_fetch(32'h300, -1, -1, 1);
        do_fetch(32'h304, -1, -1, 0);

        // randomized traffic over a few sets and tags
        for (int k = 0; k < 80; k++) begin
            a = (tags[$urandom_range(3, 0)] << 10) |
                (32'($urandom_range(3, 0)) << 4) |
                (32'($urandom_range(3, 0)) << 2);
            wait_lo = 0;
            wait_hi = $urandom_range(2, 0);
            if ($urandom_range(7, 0) == 0) do_flush();
            do_fetch(a,
                     ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                     ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                     0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
